// File: rtl/pipe_mux_n_1.sv
// Registered N:1 word multiplexer with stall/flush, valid bit and out-of-range select tracking.
// Out-of-range selects emit a programmable default word and bump a sticky flag and saturating counter.
module pipe_mux_n_1 #(
    parameter int          WIDTH   = 32,
    parameter int          N_IN    = 3,
    parameter int          SEL_W   = 2,
    parameter logic [31:0] DEFAULT = 32'h0000_0000,
    parameter int          CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN*WIDTH-1:0]   data_in,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    output logic                    sel_err,
    output logic [CNT_W-1:0]        err_count
);

    localparam logic [WIDTH-1:0] DEFAULT_WORD = WIDTH'(DEFAULT);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    generate
        if ((2 ** SEL_W) < N_IN) begin : g_sel_w_check
            $fatal(1, "pipe_mux_n_1: SEL_W=%0d cannot address N_IN=%0d inputs", SEL_W, N_IN);
        end
        if ((N_IN < 2) || (N_IN > 16)) begin : g_n_in_check
            $fatal(1, "pipe_mux_n_1: N_IN=%0d outside 2..16", N_IN);
        end
    endgenerate

    logic [WIDTH-1:0] sel_word;
    logic             sel_in_range;

    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q, sel_err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    // Compare against each legal index so an out-of-range select never slices past data_in.
    always_comb begin
        sel_word     = DEFAULT_WORD;
        sel_in_range = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_word     = data_in[i*WIDTH +: WIDTH];
                sel_in_range = 1'b1;
            end
        end
    end

    // Flush beats stall; stall beats capture.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        sel_err_d   = sel_err_q;
        err_count_d = err_count_q;
        if (flush) begin
            out_d       = '0;
            out_valid_d = 1'b0;
        end else if (!stall) begin
            if (in_valid) begin
                out_valid_d = 1'b1;
                out_d       = sel_word;
                if (!sel_in_range) begin
                    sel_err_d = 1'b1;
                    if (err_count_q != CNT_MAX) begin
                        err_count_d = err_count_q + CNT_W'(1);
                    end
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_pipe_mux_n_1.sv
// Self-checking bench for pipe_mux_n_1: two parameterisations driven together and compared
// every cycle against a spec-level reference model.
module tb_pipe_mux_n_1;

    localparam int          W_A   = 32;
    localparam int          N_A   = 3;
    localparam int          S_A   = 2;
    localparam int          C_A   = 2;
    localparam logic [31:0] DEF_A = 32'hDEAD_BEEF;

    localparam int          W_B   = 8;
    localparam int          N_B   = 5;
    localparam int          S_B   = 3;
    localparam int          C_B   = 8;
    localparam logic [31:0] DEF_B = 32'h1234_56A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, flush, stall, in_valid;
    logic [N_A*W_A-1:0] data_a;
    logic [N_B*W_B-1:0] data_b;
    logic [S_A-1:0]     sel_a;
    logic [S_B-1:0]     sel_b;
    logic [W_A-1:0]     out_a;
    logic [W_B-1:0]     out_b;
    logic               valid_a, valid_b, err_a, err_b;
    logic [C_A-1:0]     cnt_a;
    logic [C_B-1:0]     cnt_b;

    pipe_mux_n_1 #(.WIDTH(W_A), .N_IN(N_A), .SEL_W(S_A), .DEFAULT(DEF_A), .CNT_W(C_A)) dut_a (
        .clk(clk), .rst(rst), .data_in(data_a), .sel(sel_a), .in_valid(in_valid),
        .stall(stall), .flush(flush), .out(out_a), .out_valid(valid_a),
        .sel_err(err_a), .err_count(cnt_a)
    );

    pipe_mux_n_1 #(.WIDTH(W_B), .N_IN(N_B), .SEL_W(S_B), .DEFAULT(DEF_B), .CNT_W(C_B)) dut_b (
        .clk(clk), .rst(rst), .data_in(data_b), .sel(sel_b), .in_valid(in_valid),
        .stall(stall), .flush(flush), .out(out_b), .out_valid(valid_b),
        .sel_err(err_b), .err_count(cnt_b)
    );

    logic [31:0] words [2][8];
    int          n_in  [2];
    int          c_max [2];
    logic [31:0] mask  [2];
    logic [31:0] def_w [2];

    logic [31:0] m_out [2];
    logic        m_val [2];
    logic        m_err [2];
    int          m_cnt [2];

    int checks = 0;
    int errors = 0;

    always_comb begin
        data_a = '0;
        data_b = '0;
        for (int i = 0; i < N_A; i++) data_a[i*W_A +: W_A] = words[0][i];
        for (int i = 0; i < N_B; i++) data_b[i*W_B +: W_B] = words[1][i][W_B-1:0];
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic stepModel(input int k, input bit r, input bit f, input bit s, input bit v, input int sel);
        if (r) begin
            m_out[k] = 0; m_val[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
        end else if (f) begin
            m_out[k] = 0; m_val[k] = 0;
        end else if (!s) begin
            if (v) begin
                m_val[k] = 1;
                if (sel < n_in[k]) begin
                    m_out[k] = words[k][sel] & mask[k];
                end else begin
                    m_out[k] = def_w[k];
                    m_err[k] = 1;
                    if (m_cnt[k] < c_max[k]) m_cnt[k] = m_cnt[k] + 1;
                end
            end else begin
                m_val[k] = 0;
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit f, input bit s, input bit v, input int sa, input int sb);
        rst = r; flush = f; stall = s; in_valid = v;
        sel_a = S_A'(sa);
        sel_b = S_B'(sb);
        @(posedge clk);
        stepModel(0, r, f, s, v, sa);
        stepModel(1, r, f, s, v, sb);
        #1;
        checkOutput("a_out",   out_a,          m_out[0]);
        checkOutput("a_valid", 32'(valid_a),   32'(m_val[0]));
        checkOutput("a_err",   32'(err_a),     32'(m_err[0]));
        checkOutput("a_cnt",   32'(cnt_a),     32'(m_cnt[0]));
        checkOutput("b_out",   32'(out_b),     m_out[1]);
        checkOutput("b_valid", 32'(valid_b),   32'(m_val[1]));
        checkOutput("b_err",   32'(err_b),     32'(m_err[1]));
        checkOutput("b_cnt",   32'(cnt_b),     32'(m_cnt[1]));
    endtask

    initial begin
        n_in[0] = N_A;  n_in[1] = N_B;
        c_max[0] = 3;   c_max[1] = 255;
        mask[0] = 32'hFFFF_FFFF; mask[1] = 32'h0000_00FF;
        def_w[0] = DEF_A; def_w[1] = DEF_B & 32'h0000_00FF;
        for (int k = 0; k < 2; k++) begin
            m_out[k] = 0; m_val[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
            for (int i = 0; i < 8; i++) words[k][i] = 0;
        end
        words[0][0] = 32'hAAAA_AAAA;
        words[0][1] = 32'hBBBB_BBBB;
        words[0][2] = 32'hCCCC_CCCC;
        for (int i = 0; i < N_B; i++) words[1][i] = 32'h10 + 32'(i * 17);
        rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; sel_a = '0; sel_b = '0;

        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("plan_rst_out", out_a, 32'h0);

        applyStimulus(0, 0, 0, 1, 0, 4);
        checkOutput("plan_sel0", out_a, 32'hAAAA_AAAA);
        checkOutput("plan_b_sel4", 32'(out_b), 32'h54);
        applyStimulus(0, 0, 0, 1, 1, 5);
        applyStimulus(0, 0, 0, 1, 2, 6);
        checkOutput("plan_sel2", out_a, 32'hCCCC_CCCC);
        checkOutput("plan_b_default", 32'(out_b), 32'hA5);

        applyStimulus(0, 0, 0, 1, 3, 7);
        checkOutput("plan_oor_out", out_a, 32'hDEAD_BEEF);
        checkOutput("plan_oor_cnt", 32'(cnt_a), 32'd1);
        applyStimulus(0, 0, 0, 1, 0, 0);

        applyStimulus(0, 0, 0, 1, 1, 4);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 2, 2);
        checkOutput("plan_stall_hold", out_a, 32'hBBBB_BBBB);
        applyStimulus(0, 0, 0, 1, 2, 3);
        checkOutput("plan_stall_release", out_a, 32'hCCCC_CCCC);

        applyStimulus(0, 1, 1, 1, 3, 5);
        checkOutput("plan_flush_cnt", 32'(cnt_a), 32'd1);

        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 3, 5 + (i % 3));
        checkOutput("plan_saturated", 32'(cnt_a), 32'd3);
        applyStimulus(1, 0, 0, 1, 3, 7);
        applyStimulus(0, 0, 0, 1, 2, 3);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("plan_idle_hold", out_a, 32'hCCCC_CCCC);

        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < 2; k++)
                    for (int i = 0; i < 8; i++) words[k][i] = $urandom;
            end
            applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0,
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_mux_n_1.md
Name: pipe_mux_n_1

Overview:
- Parametrised, registered N:1 word multiplexer for the pipelined datapath; generalises the fixed 32-bit 3:1 select used in the single-cycle datapath.
- Drives forwarding/ALU-source selection in the pipeline.
- Adds a pipeline register with stall and flush, a valid bit, and defined handling of out-of-range selects.
- An out-of-range select produces a programmable default word and is recorded in a sticky flag and a saturating counter.

Parameters:
- WIDTH, 32: data word width in bits.
- N_IN, 3: number of data inputs, 2 to 16.
- SEL_W, 2: select width; must satisfy 2**SEL_W >= N_IN.
- DEFAULT, 32'h0000_0000: word output when the select is out of range; truncated or zero-extended to WIDTH.
- CNT_W, 8: width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- data_in  input  N_IN*WIDTH  flattened inputs; input i occupies bits [i*WIDTH +: WIDTH].
- sel  input  SEL_W  input select.
- in_valid  input  1  sel/data_in are meaningful this cycle.
- stall  input  1  freeze the output stage.
- flush  input  1  invalidate the output stage.
- out  output  WIDTH  registered selected word.
- out_valid  output  1  out holds a captured word.
- sel_err  output  1  sticky: an out-of-range select has been captured since reset.
- err_count  output  CNT_W  number of out-of-range captures, saturating.

Behaviour:
- One clock, one register stage. All state updates on the rising edge of clk.
- Latency: a word captured at edge k appears on out/out_valid right after edge k.
- Per-edge priority: rst > flush > stall > capture > idle.
- Reset (rst=1 at edge): out=0, out_valid=0, sel_err=0, err_count=0. A reset asserted mid-stream discards the stage contents; the first capture is possible on the first edge with rst=0.
- Flush (rst=0, flush=1):
  - out<=0 and out_valid<=0.
  - sel_err and err_count are unchanged.
  - Any in_valid input that cycle is dropped and not counted, even if out of range.
  - Flush overrides stall.
- Stall (rst=0, flush=0, stall=1): out, out_valid, sel_err and err_count all hold. Inputs are ignored and not counted.
- Capture (rst=0, flush=0, stall=0, in_valid=1):
  - out_valid<=1.
  - If sel < N_IN: out<=data_in[sel*WIDTH +: WIDTH].
  - Else: out<=DEFAULT, sel_err<=1, and err_count<=err_count+1, saturating at 2**CNT_W-1 with no wrap.
- Idle (rst=0, flush=0, stall=0, in_valid=0): out_valid<=0; out holds its last value; no counting.
- Combinational selection depends only on current sel/data_in. There are no latches: every output is fully assigned on every path.
- Elaboration-time check: 2**SEL_W < N_IN is a fatal error.

Test Plan:
1. Reset and capture: rst for 2 cycles, then N_IN=3 and data_in={32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA}.
   - While rst is held: out=0, out_valid=0.
   - in_valid=1 with sel=0,1,2 on consecutive edges: out=AAAA_AAAA, BBBB_BBBB, CCCC_CCCC one edge after each; out_valid=1 throughout.
2. Out-of-range select: sel=3, in_valid=1, DEFAULT=32'hDEAD_BEEF.
   - Next edge: out=DEAD_BEEF, sel_err=1, err_count=1.
   - Then sel=0: out=AAAA_AAAA, sel_err stays 1.
3. Stall: capture BBBB_BBBB, then stall=1 for 3 cycles while sel=2 and in_valid=1.
   - During the stall: out=BBBB_BBBB and out_valid=1 hold.
   - Edge after stall drops: out=CCCC_CCCC.
4. Flush priority: with out_valid=1, assert flush=1, stall=1, in_valid=1, sel=3 together.
   - Result: out=0, out_valid=0, err_count unchanged.
5. Saturation: CNT_W=2, capture sel=3 five times.
   - err_count sequence: 1, 2, 3, 3, 3.
   - Mid-run rst clears err_count=0 and sel_err=0.
6. Parametric: WIDTH=8, N_IN=5, SEL_W=3.
   - sel=4 selects input 4.
   - sel=5, 6 or 7 give DEFAULT[7:0] and increment err_count.
   - Idle cycle (in_valid=0) gives out_valid=0 with out holding.
